// File: rtl/edge_capture.sv
// edge_capture: multi-channel input conditioner for asynchronous level inputs.
// Each channel is synchronised, then filtered by a stable-count filter, then
// edge-detected according to its 2-bit mode. A commit of a new filtered level
// can raise a one-cycle event pulse (Y) and set a sticky flag (write-1-to-clear).
// irq is the OR of all sticky flags.
//
// Handshake note: there is no valid/ready handshake. Y is a one-cycle strobe
// that coincides with the first cycle A_filt shows the newly committed level.
// clr is a level-sampled strobe that acts only on the edges where it is high,
// and a simultaneous new event wins over clr.
module edge_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     A,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     A_filt,
  output logic [WIDTH-1:0]     Y,
  output logic [WIDTH-1:0]     flag,
  output logic                 irq
);

  // Synchroniser chain; stage 0 samples the pads, the last stage feeds the filter.
  logic [WIDTH-1:0]             sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]             s;

  // Per-channel filter state and registered outputs.
  logic [WIDTH-1:0][FILT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]             filt_q, filt_d;
  logic [WIDTH-1:0]             y_q, y_d;
  logic [WIDTH-1:0]             flag_q, flag_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous inputs through the synchroniser flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= A;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Stable-count filter, edge classification and sticky flag next-state.
  // The count compares against the live filt_len, so lowering filt_len below
  // a running count commits on the very next edge.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    y_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
        // Rising commit uses mode bit 0, falling commit uses mode bit 1.
        y_d[i]    = s[i] ? mode[2*i] : mode[2*i+1];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // A new event has priority over a clear in the same cycle.
    flag_d = y_d | (flag_q & ~clr);
  end

  // Register filter counters, filtered level, event pulse and sticky flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      filt_q <= '0;
      y_q    <= '0;
      flag_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      y_q    <= y_d;
      flag_q <= flag_d;
    end
  end

  assign A_filt = filt_q;
  assign Y      = y_q;
  assign flag   = flag_q;
  assign irq    = |flag_q;

endmodule

// File: tb/tb_edge_capture.sv
// Testbench for edge_capture: directed vectors, expected responses queued by
// the stimulus process and checked by an independent negedge monitor.
// Edge numbering: cyc counts rising clock edges; after edge E the stimulus may
// change A, and a commit is due at edge E + SYNC_STAGES + 1 + filt_len.
module tb_edge_capture;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int FW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk      = 1'b0;
  logic          rstn     = 1'b1;
  logic [W-1:0]  A        = '0;
  logic [2*W-1:0] mode    = '0;
  logic [FW-1:0] filt_len = '0;
  logic [W-1:0]  clr      = '0;
  logic [W-1:0]  A_filt;
  logic [W-1:0]  Y;
  logic [W-1:0]  flag;
  logic          irq;

  edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .A        (A),
    .mode     (mode),
    .filt_len (filt_len),
    .clr      (clr),
    .A_filt   (A_filt),
    .Y        (Y),
    .flag     (flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int           cyc;
    logic [W-1:0] y;
    logic [W-1:0] fl;
    logic [W-1:0] af;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
    end
  endtask

  task automatic expect_at(input int c, input logic [W-1:0] y, input logic [W-1:0] fl,
                           input logic [W-1:0] af);
    exp_t e;
    e.cyc = c;
    e.y   = y;
    e.fl  = fl;
    e.af  = af;
    exp_q.push_back(e);
  endtask

  // Monitor: any event pulse, or a queued snapshot for this cycle, pops one entry.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_check: entry for cycle %0d never matched (now %0d)", e.cyc, cyc);
      end
      if (Y != '0 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event at cycle %0d: Y=%h, expected no event", cyc, Y);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("Y", Y, e.y);
          check("flag", flag, e.fl);
          check("A_filt", A_filt, e.af);
          check("irq", irq, |e.fl);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;

    // Async reset from idle, checked before any clock edge.
    #2 rstn = 1'b0;
    #1;
    check("rst_A_filt", A_filt, 0);
    check("rst_Y", Y, 0);
    check("rst_flag", flag, 0);
    check("rst_irq", irq, 0);
    tick(3);
    rstn = 1'b1;
    tick(2);

    // Rise, no filter, channel 0 (mode: ch0/1/3-7 rise, ch2 fall).
    mode = 16'h5565;
    A[0] = 1'b1;
    e0 = cyc;
    expect_at(e0 + 3, 8'h01, 8'h01, 8'h01);
    expect_at(e0 + 4, 8'h00, 8'h01, 8'h01);
    wait_until(e0 + 6);

    // Glitch of 3 cycles on ch1 with filt_len=3: rejected.
    filt_len = 4'd3;
    A[1] = 1'b1;
    e0 = cyc;
    tick(3);
    A[1] = 1'b0;
    expect_at(e0 + 8, 8'h00, 8'h01, 8'h01);
    wait_until(e0 + 9);

    // Held high: commit exactly at edge 6.
    A[1] = 1'b1;
    e0 = cyc;
    expect_at(e0 + 5, 8'h00, 8'h01, 8'h01);
    expect_at(e0 + 6, 8'h02, 8'h03, 8'h03);
    wait_until(e0 + 7);

    // Lowering filt_len below a running count commits on the next edge (ch4).
    filt_len = 4'd7;
    A[4] = 1'b1;
    e0 = cyc;
    expect_at(e0 + 6, 8'h00, 8'h03, 8'h03);
    wait_until(e0 + 6);
    filt_len = 4'd2;
    expect_at(e0 + 7, 8'h10, 8'h13, 8'h13);
    wait_until(e0 + 9);

    // ch4 falls (no event, rise-only mode) while its flag is cleared.
    A[4] = 1'b0;
    clr  = 8'h10;
    e0 = cyc;
    expect_at(e0 + 1, 8'h00, 8'h03, 8'h13);
    expect_at(e0 + 5, 8'h00, 8'h03, 8'h03);
    tick(1);
    clr = '0;
    wait_until(e0 + 7);

    // ch2 fall-only: rising commit silent, falling commit pulses.
    filt_len = 4'd0;
    A[2] = 1'b1;
    e0 = cyc;
    expect_at(e0 + 3, 8'h00, 8'h03, 8'h07);
    wait_until(e0 + 5);
    A[2] = 1'b0;
    expect_at(e0 + 8, 8'h04, 8'h07, 8'h03);
    wait_until(e0 + 10);

    // ch2 both edges: two pulses.
    mode = 16'h5575;
    A[2] = 1'b1;
    e0 = cyc;
    expect_at(e0 + 3, 8'h04, 8'h07, 8'h07);
    wait_until(e0 + 5);
    A[2] = 1'b0;
    expect_at(e0 + 8, 8'h04, 8'h07, 8'h03);
    wait_until(e0 + 10);

    // ch2 off: clear its flag, then toggle with no events.
    mode = 16'h5545;
    clr  = 8'h04;
    e0 = cyc;
    expect_at(e0 + 1, 8'h00, 8'h03, 8'h03);
    tick(1);
    clr = '0;
    A[2] = 1'b1;
    e0 = cyc;
    expect_at(e0 + 3, 8'h00, 8'h03, 8'h07);
    wait_until(e0 + 5);
    A[2] = 1'b0;
    expect_at(e0 + 8, 8'h00, 8'h03, 8'h03);
    wait_until(e0 + 10);

    // ch3 clear/set collision: set wins, flag stays after clr drops.
    A[3] = 1'b1;
    e0 = cyc;
    expect_at(e0 + 3, 8'h08, 8'h0B, 8'h0B);
    wait_until(e0 + 4);
    A[3] = 1'b0;
    expect_at(e0 + 7, 8'h00, 8'h0B, 8'h03);
    wait_until(e0 + 8);
    A[3] = 1'b1;
    expect_at(e0 + 11, 8'h08, 8'h0B, 8'h0B);
    expect_at(e0 + 12, 8'h00, 8'h0B, 8'h0B);
    wait_until(e0 + 10);
    clr = 8'h08;
    tick(1);
    clr = '0;
    wait_until(e0 + 13);

    // clr alone clears ch3; then clear everything, irq drops.
    clr = 8'h08;
    e0 = cyc;
    expect_at(e0 + 1, 8'h00, 8'h03, 8'h0B);
    tick(1);
    clr = '0;
    wait_until(e0 + 3);
    clr = 8'h0F;
    e0 = cyc;
    expect_at(e0 + 1, 8'h00, 8'h00, 8'h0B);
    tick(1);
    clr = '0;
    wait_until(e0 + 3);

    // Multi-channel: all rise-only, all fall silently, then all rise together.
    mode = 16'h5555;
    A = 8'h00;
    e0 = cyc;
    expect_at(e0 + 3, 8'h00, 8'h00, 8'h00);
    wait_until(e0 + 5);
    A = 8'hFF;
    e0 = cyc;
    expect_at(e0 + 3, 8'hFF, 8'hFF, 8'hFF);
    expect_at(e0 + 4, 8'h00, 8'hFF, 8'hFF);
    wait_until(e0 + 5);
    clr = 8'h0F;
    e0 = cyc;
    expect_at(e0 + 1, 8'h00, 8'hF0, 8'hFF);
    tick(1);
    clr = '0;
    wait_until(e0 + 3);

    // Async reset mid-filter with filt_len=7.
    filt_len = 4'd7;
    A = 8'h00;
    e0 = cyc;
    wait_until(e0 + 5);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_A_filt", A_filt, 0);
    check("async_rst_Y", Y, 0);
    check("async_rst_flag", flag, 0);
    check("async_rst_irq", irq, 0);
    A = 8'h01;
    tick(2);
    rstn = 1'b1;
    e0 = cyc;
    expect_at(e0 + 9, 8'h00, 8'h00, 8'h00);
    expect_at(e0 + 10, 8'h01, 8'h01, 8'h01);
    wait_until(e0 + 12);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
